// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_ctrl_if                                              |
// | Brief    : Stall/flush/halt signal bundle between sequencer and CPU  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [31:0] excepttype_i;
    logic [31:0] epc_i;
    logic        halt_req;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        halt_ack;
    logic [31:0] stall_cycles;

    modport master (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, epc_i, halt_req,
        output stall, flush, new_pc, halt_ack, stall_cycles
    );

    modport slave (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, epc_i, halt_req,
        input  stall, flush, new_pc, halt_ack, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_ctrl                                                 |
// | Brief    : 5-stage pipeline sequencer: stall merge, exception flush, |
// |            debug halt drain and saturating stall-cycle counter       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pipe_ctrl #(
    parameter logic [31:0] EBASE        = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    pipe_ctrl_if.master    bus
);

    localparam logic [1:0]  c_st_run    = 2'd0;
    localparam logic [1:0]  c_st_drain  = 2'd1;
    localparam logic [1:0]  c_st_halted = 2'd2;
    // A zero drain length still needs one quiet cycle before freezing
    localparam logic [31:0] c_drain_load = (DRAIN_CYCLES == 0) ? 32'd1 : 32'(DRAIN_CYCLES);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_drain_cnt;
    logic [31:0] w_drain_cnt_nxt;
    logic        r_halt_ack;
    logic [31:0] r_stall_cycles;
    logic        w_exc;
    logic [31:0] w_new_pc;
    logic [5:0]  w_stall;
    logic        w_count_en;

    assign w_exc = (bus.excepttype_i != 32'h0) && (r_state != c_st_halted);

    always_comb begin
        w_new_pc = 32'h0;
        if (w_exc) begin
            case (bus.excepttype_i)
                32'h0000_0001: w_new_pc = EBASE + 32'h20;
                32'h0000_000e: w_new_pc = bus.epc_i;
                default:       w_new_pc = EBASE + 32'h40;
            endcase
        end
    end

    always_comb begin
        w_stall = 6'b000000;
        if (w_exc)                      w_stall = 6'b000000;
        else if (r_state == c_st_halted) w_stall = 6'b111111;
        else if (bus.stallreq_mem)      w_stall = 6'b011111;
        else if (bus.stallreq_ex)       w_stall = 6'b001111;
        else if (bus.stallreq_id)       w_stall = 6'b000111;
        else if (r_state == c_st_drain) w_stall = 6'b000011;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            c_st_run: begin
                if (bus.halt_req) begin
                    w_state_nxt     = c_st_drain;
                    w_drain_cnt_nxt = c_drain_load;
                end
            end
            c_st_drain: begin
                if (!bus.halt_req) begin
                    w_state_nxt     = c_st_run;
                    w_drain_cnt_nxt = 32'h0;
                end else if (w_exc) begin
                    w_drain_cnt_nxt = c_drain_load;
                end else if (!bus.stallreq_ex && !bus.stallreq_mem) begin
                    // ID hazards only bubble the back half, so drain continues
                    if (r_drain_cnt <= 32'd1) begin
                        w_state_nxt     = c_st_halted;
                        w_drain_cnt_nxt = 32'h0;
                    end else begin
                        w_drain_cnt_nxt = r_drain_cnt - 32'd1;
                    end
                end
            end
            c_st_halted: begin
                if (!bus.halt_req) w_state_nxt = c_st_run;
            end
            default: begin
                w_state_nxt     = c_st_run;
                w_drain_cnt_nxt = 32'h0;
            end
        endcase
    end

    assign w_count_en = w_stall[0] && (r_state != c_st_halted) && (r_stall_cycles != 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= c_st_run;
            r_drain_cnt    <= 32'h0;
            r_halt_ack     <= 1'b0;
            r_stall_cycles <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_halt_ack  <= (w_state_nxt == c_st_halted);
            if (w_count_en) r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_exc;
    assign bus.new_pc       = w_new_pc;
    assign bus.halt_ack     = r_halt_ack;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipe_ctrl                                              |
// | Brief    : Directed self-checking bench for pipe_ctrl                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl;

    logic clk;
    logic reset_n;
    int   r_total;
    int   r_bad;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .EBASE        (32'h0000_0000),
        .DRAIN_CYCLES (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_total++;
        if (obs !== exp) begin
            r_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 2ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        r_total = 0;
        r_bad   = 0;
        reset_n          = 1'b0;
        bus.stallreq_id  = 1'b0;
        bus.stallreq_ex  = 1'b0;
        bus.stallreq_mem = 1'b0;
        bus.excepttype_i = 32'h0;
        bus.epc_i        = 32'h0;
        bus.halt_req     = 1'b0;
        #3;
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h0);
        chk("rst_newpc", bus.new_pc, 32'h0);
        chk("rst_ack", 32'(bus.halt_ack), 32'h0);
        chk("rst_cnt", bus.stall_cycles, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // EX stall for three cycles
        bus.stallreq_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ex_stall", 32'(bus.stall), 32'h0F);
            tick();
        end
        bus.stallreq_ex = 1'b0;
        settle();
        chk("ex_cnt", bus.stall_cycles, 32'd3);
        chk("ex_release", 32'(bus.stall), 32'h0);
        tick();

        // MEM beats ID, then ID alone
        bus.stallreq_id  = 1'b1;
        bus.stallreq_mem = 1'b1;
        settle();
        chk("mem_id", 32'(bus.stall), 32'h1F);
        tick();
        bus.stallreq_mem = 1'b0;
        settle();
        chk("id_only", 32'(bus.stall), 32'h07);
        tick();
        bus.stallreq_id = 1'b0;
        settle();
        chk("cnt5", bus.stall_cycles, 32'd5);
        tick();

        // Syscall overrides an EX stall for one cycle
        bus.stallreq_ex  = 1'b1;
        bus.excepttype_i = 32'h8;
        settle();
        chk("sys_flush", 32'(bus.flush), 32'h1);
        chk("sys_pc", bus.new_pc, 32'h40);
        chk("sys_stall", 32'(bus.stall), 32'h0);
        tick();
        bus.excepttype_i = 32'h0;
        settle();
        chk("sys_cnt", bus.stall_cycles, 32'd5);
        chk("post_flush", 32'(bus.flush), 32'h0);
        chk("post_stall", 32'(bus.stall), 32'h0F);
        bus.stallreq_ex = 1'b0;
        tick();

        // Vector mapping
        bus.excepttype_i = 32'he;
        bus.epc_i        = 32'h0000_1234;
        settle();
        chk("eret_flush", 32'(bus.flush), 32'h1);
        chk("eret_pc", bus.new_pc, 32'h1234);
        tick();
        bus.excepttype_i = 32'h1;
        settle();
        chk("int_pc", bus.new_pc, 32'h20);
        tick();
        bus.excepttype_i = 32'ha;
        settle();
        chk("ri_pc", bus.new_pc, 32'h40);
        tick();
        bus.excepttype_i = 32'h3;
        settle();
        chk("other_pc", bus.new_pc, 32'h40);
        tick();
        bus.excepttype_i = 32'h0;
        settle();
        chk("none_pc", bus.new_pc, 32'h0);
        chk("cnt5b", bus.stall_cycles, 32'd5);
        tick();

        // Plain drain: four drain cycles then halt
        bus.halt_req = 1'b1;
        settle();
        chk("h_req_run", 32'(bus.stall), 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("drain_stall", 32'(bus.stall), 32'h03);
            chk("drain_ack", 32'(bus.halt_ack), 32'h0);
            tick();
        end
        settle();
        chk("halt_stall", 32'(bus.stall), 32'h3F);
        chk("halt_ack", 32'(bus.halt_ack), 32'h1);
        chk("halt_cnt", bus.stall_cycles, 32'd9);
        tick();
        bus.excepttype_i = 32'h8;
        settle();
        chk("halt_noflush", 32'(bus.flush), 32'h0);
        chk("halt_exc_stall", 32'(bus.stall), 32'h3F);
        chk("halt_cnt_hold", bus.stall_cycles, 32'd9);
        tick();
        bus.excepttype_i = 32'h0;
        bus.halt_req     = 1'b0;
        settle();
        chk("unhalt_same", 32'(bus.stall), 32'h3F);
        tick();
        settle();
        chk("unhalt_ack", 32'(bus.halt_ack), 32'h0);
        chk("unhalt_stall", 32'(bus.stall), 32'h0);
        tick();

        // Drain with two MEM wait cycles: halt arrives two cycles later
        bus.halt_req = 1'b1;
        tick();
        settle();
        chk("d2_stall0", 32'(bus.stall), 32'h03);
        tick();
        bus.stallreq_mem = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("d2_mem", 32'(bus.stall), 32'h1F);
            tick();
        end
        bus.stallreq_mem = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("d2_drain", 32'(bus.stall), 32'h03);
            chk("d2_noack", 32'(bus.halt_ack), 32'h0);
            tick();
        end
        settle();
        chk("d2_ack", 32'(bus.halt_ack), 32'h1);
        bus.halt_req = 1'b0;
        tick();
        tick();

        // Exception two cycles into drain reloads the full count
        bus.halt_req = 1'b1;
        tick();
        tick();
        tick();
        bus.excepttype_i = 32'h8;
        settle();
        chk("d3_flush", 32'(bus.flush), 32'h1);
        chk("d3_stall", 32'(bus.stall), 32'h0);
        tick();
        bus.excepttype_i = 32'h0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("d3_drain", 32'(bus.stall), 32'h03);
            chk("d3_noack", 32'(bus.halt_ack), 32'h0);
            tick();
        end
        settle();
        chk("d3_ack", 32'(bus.halt_ack), 32'h1);
        bus.halt_req = 1'b0;
        tick();
        tick();

        // Counter saturation
        dut.r_stall_cycles = 32'hFFFF_FFFE;
        bus.stallreq_ex = 1'b1;
        tick();
        tick();
        tick();
        bus.stallreq_ex = 1'b0;
        settle();
        chk("sat", bus.stall_cycles, 32'hFFFF_FFFF);
        tick();
        settle();
        chk("sat_hold", bus.stall_cycles, 32'hFFFF_FFFF);
        tick();

        // Async reset while halted
        bus.halt_req = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        settle();
        chk("pre_rst_ack", 32'(bus.halt_ack), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("arst_ack", 32'(bus.halt_ack), 32'h0);
        chk("arst_stall", 32'(bus.stall), 32'h0);
        chk("arst_cnt", bus.stall_cycles, 32'h0);
        bus.halt_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", r_total, r_bad);
        $finish;
    end

endmodule
`default_nettype wire
